// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline-stage register with an optional
// two-entry skid buffer, used between MIPS datapath stages.
//
// Parameters
//   WIDTH        payload width in bits
//   RESET_VALUE  payload loaded into main and skid on reset or flush
//   SKID         1: two entries, registered in_ready
//                0: one entry, in_ready = ~out_valid | out_ready
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous squash, empties the stage
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload this cycle
//   in_data    upstream payload
//   out_valid  main register holds a payload
//   out_ready  downstream accepts this cycle
//   out_data   main register payload
//   occupancy  number of held entries (0, 1 or 2)

module pipe_skid_reg #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               SKID        = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // Encoding equals the entry count so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_p0;
   state_t           state_next;
   logic [WIDTH-1:0] main_p0;
   logic [WIDTH-1:0] skid_p0;

   logic in_fire;
   logic out_fire;
   logic main_load;
   logic main_from_skid;
   logic skid_load;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // ---- stage register: control state ----
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_p0 <= EMPTY;
      end else begin
         state_p0 <= state_next;
      end
   end

   // Next state plus the payload-register write enables that go with it.
   always_comb begin
      state_next     = state_p0;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      case (state_p0)
         EMPTY: begin
            if (in_fire) begin
               state_next = BUSY;
               main_load  = 1'b1;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_load = 1'b1;
            end else if (in_fire && SKID) begin
               // Downstream stalled: park the new payload behind main.
               state_next = FULL;
               skid_load  = 1'b1;
            end else if (out_fire) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_next     = BUSY;
               main_load      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   // Outputs are functions of state only, except the SKID=0 in_ready
   // which deliberately passes out_ready through combinationally.
   always_comb begin
      out_valid = (state_p0 != EMPTY);
      occupancy = state_p0;
      out_data  = main_p0;
      if (SKID) begin
         in_ready = (state_p0 != FULL);
      end else begin
         in_ready = (state_p0 == EMPTY) | out_ready;
      end
   end

   // ---- stage register: payload ----
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         main_p0 <= RESET_VALUE;
         skid_p0 <= RESET_VALUE;
      end else begin
         if (main_load) begin
            main_p0 <= main_from_skid ? skid_p0 : in_data;
         end
         if (skid_load) begin
            skid_p0 <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

   localparam logic [31:0] RV1 = 32'h0000_0000;
   localparam logic [31:0] RV0 = 32'hDEAD_BEEF;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        ir1, ov1;
   logic [31:0] od1;
   logic [1:0]  occ1;
   logic        ir0, ov0;
   logic [31:0] od0;
   logic [1:0]  occ0;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_skid_reg #(.WIDTH(32), .RESET_VALUE(RV1), .SKID(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .occupancy(occ1)
   );

   pipe_skid_reg #(.WIDTH(32), .RESET_VALUE(RV0), .SKID(1'b0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
      .occupancy(occ0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          chk;
      logic        rst;
      logic        flush;
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        ir;
      logic        ov;
      logic [31:0] od;
      logic [1:0]  occ;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit chk, input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy, input logic ir,
                      input logic ov, input logic [31:0] od, input logic [1:0] occ);
      vec_t v;
      v.chk = chk; v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
      v.ir = ir; v.ov = ov; v.od = od; v.occ = occ;
      tbl.push_back(v);
   endtask

   // Reference model: plain FIFO per instance plus the last head value.
   logic [31:0] q1[$];
   logic [31:0] q0[$];
   logic [31:0] last1, last0;

   initial begin
      int flush_cnt;
      bit pop, push;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // Expected values are the outputs during the cycle, before its edge.
      //   chk rst fl  iv  data          ordy ir  ov  out_data      occ
      add(0, 1, 0, 1, 32'h12341234, 0, 0, 0, 32'h0,        2'd0);
      add(1, 1, 0, 1, 32'h12341234, 0, 1, 0, 32'h0,        2'd0);
      add(1, 0, 0, 1, 32'h12341234, 0, 1, 0, 32'h0,        2'd0);
      add(1, 0, 0, 0, 32'h0,        1, 1, 1, 32'h12341234, 2'd1);
      add(1, 0, 0, 1, 32'h1,        1, 1, 0, 32'h12341234, 2'd0);
      add(1, 0, 0, 1, 32'h2,        1, 1, 1, 32'h1,        2'd1);
      add(1, 0, 0, 1, 32'h3,        1, 1, 1, 32'h2,        2'd1);
      add(1, 0, 0, 1, 32'h4,        1, 1, 1, 32'h3,        2'd1);
      add(1, 0, 0, 0, 32'h0,        1, 1, 1, 32'h4,        2'd1);
      add(1, 0, 0, 1, 32'hA,        0, 1, 0, 32'h4,        2'd0);
      add(1, 0, 0, 1, 32'hB,        0, 1, 1, 32'hA,        2'd1);
      add(1, 0, 0, 1, 32'hC,        0, 0, 1, 32'hA,        2'd2);
      add(1, 0, 0, 1, 32'hC,        1, 0, 1, 32'hA,        2'd2);
      add(1, 0, 0, 1, 32'hC,        1, 1, 1, 32'hB,        2'd1);
      add(1, 0, 0, 0, 32'h0,        1, 1, 1, 32'hC,        2'd1);
      add(1, 0, 0, 0, 32'h0,        0, 1, 0, 32'hC,        2'd0);
      add(1, 0, 0, 1, 32'hA,        0, 1, 0, 32'hC,        2'd0);
      add(1, 0, 0, 1, 32'hB,        0, 1, 1, 32'hA,        2'd1);
      add(1, 0, 1, 1, 32'hC,        0, 0, 1, 32'hA,        2'd2);
      add(1, 0, 0, 0, 32'h0,        1, 1, 0, RV1,          2'd0);
      add(1, 0, 0, 0, 32'h0,        1, 1, 0, RV1,          2'd0);
      add(1, 0, 0, 1, 32'h43214321, 0, 1, 0, RV1,          2'd0);
      for (int k = 0; k < 5; k++)
         add(1, 0, 0, 0, 32'h0,     0, 1, 1, 32'h43214321, 2'd1);
      add(1, 0, 0, 0, 32'h0,        1, 1, 1, 32'h43214321, 2'd1);
      add(1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h43214321, 2'd0);

      foreach (tbl[i]) begin
         rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
         in_data = tbl[i].d; out_ready = tbl[i].ordy;
         #1;
         if (tbl[i].chk) begin
            check($sformatf("vec%0d in_ready", i),  {31'b0, ir1}, {31'b0, tbl[i].ir});
            check($sformatf("vec%0d out_valid", i), {31'b0, ov1}, {31'b0, tbl[i].ov});
            check($sformatf("vec%0d out_data", i),  od1, tbl[i].od);
            check($sformatf("vec%0d occupancy", i), {30'b0, occ1}, {30'b0, tbl[i].occ});
         end
         @(posedge clk); #1;
      end

      // SKID=0 instance: combinational back-pressure and pass-through.
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("s0 reset out_valid", {31'b0, ov0}, 32'd0);
      check("s0 reset out_data", od0, RV0);
      check("s0 reset occupancy", {30'b0, occ0}, 32'd0);
      check("s0 reset in_ready", {31'b0, ir0}, 32'd1);
      in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b0;
      #1;
      check("s0 empty in_ready", {31'b0, ir0}, 32'd1);
      @(posedge clk); #1;
      in_data = 32'h6;
      #1;
      check("s0 stall in_ready", {31'b0, ir0}, 32'd0);
      check("s0 busy out_valid", {31'b0, ov0}, 32'd1);
      check("s0 busy out_data", od0, 32'h5);
      check("s0 busy occupancy", {30'b0, occ0}, 32'd1);
      out_ready = 1'b1;
      #1;
      check("s0 comb in_ready", {31'b0, ir0}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      check("s0 pass out_data", od0, 32'h6);
      check("s0 pass out_valid", {31'b0, ov0}, 32'd1);
      @(posedge clk); #1;
      check("s0 drained out_valid", {31'b0, ov0}, 32'd0);
      check("s0 drained occupancy", {30'b0, occ0}, 32'd0);

      // Randomized traffic against the queue model, both instances.
      flush_cnt = 0;
      last1 = RV1; last0 = RV0;
      for (int i = 0; i < 2000; i++) begin
         rst = (i == 0) || ($urandom_range(0, 199) == 0);
         if (flush_cnt > 0) begin
            flush = 1'b1;
            flush_cnt--;
         end else if ($urandom_range(0, 49) == 0) begin
            flush = 1'b1;
            flush_cnt = $urandom_range(0, 2);
         end else begin
            flush = 1'b0;
         end
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = $urandom;
         if (((i / 100) % 2) == 1)
            out_ready = ($urandom_range(0, 3) != 0);
         else
            out_ready = ($urandom_range(0, 3) == 0);
         #1;
         if (i > 0) begin
            check("rnd1 in_ready", {31'b0, ir1}, {31'b0, (q1.size() < 2)});
            check("rnd1 out_valid", {31'b0, ov1}, {31'b0, (q1.size() != 0)});
            check("rnd1 out_data", od1, (q1.size() != 0) ? q1[0] : last1);
            check("rnd1 occupancy", {30'b0, occ1}, 32'(q1.size()));
            check("rnd0 in_ready", {31'b0, ir0}, {31'b0, (q0.size() == 0) || out_ready});
            check("rnd0 out_valid", {31'b0, ov0}, {31'b0, (q0.size() != 0)});
            check("rnd0 out_data", od0, (q0.size() != 0) ? q0[0] : last0);
            check("rnd0 occupancy", {30'b0, occ0}, 32'(q0.size()));
         end
         @(posedge clk);
         if (rst || flush) begin
            q1.delete(); q0.delete();
            last1 = RV1; last0 = RV0;
         end else begin
            pop  = (q1.size() != 0) && out_ready;
            push = in_valid && (q1.size() < 2);
            if (pop) void'(q1.pop_front());
            if (push) q1.push_back(in_data);
            if (q1.size() != 0) last1 = q1[0];
            pop  = (q0.size() != 0) && out_ready;
            push = in_valid && ((q0.size() == 0) || out_ready);
            if (pop) void'(q0.pop_front());
            if (push) q0.push_back(in_data);
            if (q0.size() != 0) last0 = q0[0];
         end
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register for the MIPS datapath. It generalises the enable/reset/clear flop into a valid/ready stage with a two-entry skid buffer, so upstream stalls no longer need a combinational enable chain. The stage sits between pipeline stages (IF/ID, ID/EX, ...) and supports a synchronous flush for branch/exception squash. A `SKID=0` mode degrades it to a single-entry register with combinational back-pressure.

## Interface
- `WIDTH`, 32: payload width in bits.
- `RESET_VALUE`, 0: value loaded into the main and skid payload registers on reset or flush.
- `SKID`, 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous squash; empties the stage.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept a payload this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  main register holds a payload.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  main register payload.
- `occupancy`  out  2  number of held entries (0, 1 or 2).

## Operation
- An input fire is `in_valid & in_ready`. An output fire is `out_valid & out_ready`.
- There are two registers: main (drives `out_data`) and skid.
- States are EMPTY (0 entries), BUSY (main only) and FULL (main and skid). FULL is unreachable when `SKID=0`.
- Transitions with `SKID=1`:
  - EMPTY: on input fire, go to BUSY with main <= `in_data`. Otherwise stay.
  - BUSY, input fire and output fire: stay in BUSY with main <= `in_data`.
  - BUSY, input fire only: go to FULL with skid <= `in_data`.
  - BUSY, output fire only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL: `in_ready`=0. On output fire, go to BUSY with main <= skid. Otherwise hold.
- With `SKID=0`, `in_ready = ~out_valid | out_ready`. EMPTY and BUSY behave as above; BUSY with input fire only cannot occur.
- Ordering is strictly FIFO. No payload is duplicated or lost except by flush.
- Priority is `rst` > `flush` > handshake logic.
- Flush:
  - The next state is EMPTY and both payload registers load `RESET_VALUE`.
  - An input fire in the flush cycle is accepted and discarded.
  - An output fire in the flush cycle counts as delivered.
- Payload registers hold their value when not written; there is no X on `out_data` after reset.
- `occupancy` = 0/1/2 for EMPTY/BUSY/FULL, taken directly from state.

## Timing
- Reset values: `out_valid`=0, `out_data`=`RESET_VALUE`, `occupancy`=0, `in_ready`=1 (both modes, since `out_valid`=0).
- Latency is 1 cycle: a payload accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N.
- With `SKID=1`:
  - `in_ready` is a pure function of state (registered, no `out_ready` path). It goes low the cycle after the stage becomes FULL.
  - It returns high one cycle after the output fire in FULL.
  - Sustained throughput is 1 payload/cycle when `out_ready`=1.
- With `SKID=0`, there is a combinational path `out_ready` -> `in_ready`, and throughput is 1/cycle.
- Reset or flush asserted in FULL takes effect at the next edge: `out_valid`=0 and `in_ready`=1 the following cycle.
- Reset or flush asserted mid-stream across multiple cycles keeps the stage EMPTY throughout.
- Inputs are sampled only at the rising edge of `clk`. `flush` and `rst` have no combinational effect on outputs.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1 and `in_data`=0x12341234, then release. While reset is asserted, `out_valid`=0, `out_data`=0 and `occupancy`=0. One edge after release, `out_valid`=1 and `out_data`=0x12341234.
- Streaming: with `out_ready`=1, send 0x1, 0x2, 0x3, 0x4 on consecutive cycles. The outputs must be 0x1..0x4 on consecutive cycles starting one cycle later, with `in_ready` high throughout.
- Skid fill:
  - Send 0xA then 0xB with `out_ready`=0. Expect `occupancy`=2 and `in_ready`=0, with `out_data`=0xA held.
  - Present 0xC and hold `in_valid` high, then raise `out_ready`. Expect 0xA, then 0xB, then 0xC, with no loss or duplication.
- Flush in FULL: start with the stage holding 0xA and 0xB and `in_valid`=1 with 0xC, then pulse `flush` for 1 cycle. Next cycle: `out_valid`=0, `occupancy`=0, `out_data`=`RESET_VALUE`. 0xC is never emitted.
- Stall hold: start BUSY with 0x43214321 and `out_ready`=0 for 5 cycles with `in_valid`=0. `out_data` must stay 0x43214321 and `out_valid` must stay 1.
- `SKID=0` instance: with `out_ready`=0 and the stage BUSY, `in_ready`=0 in the same cycle. Raising `out_ready` raises `in_ready` combinationally. A pass-through sequence of 0x5, 0x6 appears back-to-back.
